// File: rtl/seq_pkg.sv
// Shared definitions for the 1001 sequence-match logging slice.
package seq_pkg;

    localparam logic [3:0]  SEQ_PATTERN = 4'b1001;

    localparam int unsigned POS_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_log_fifo.sv
// Generic synchronous FIFO with a registered head output; no fall-through.
module seq_log_fifo
    import seq_pkg::*;
#(
    parameter int unsigned W     = POS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [lvl_w(DEPTH)-1:0]  level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign dout_o  = head_q;
    assign level_o = level_q;

    // Head is precomputed so it changes on the same edge as the pop/push.
    always_comb begin
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        head_d  = head_q;
        if (do_pop) begin
            if (level_q > LW'(1))
                head_d = mem_q[rd_q + AW'(1)];
            else if (do_push)
                head_d = din_i;
        end else if (do_push && empty_o) begin
            head_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/seq_match_logger.sv
// Tags each 1001 detection with its bit position and queues it for the control side.
// Optional SEQ_LOG_CNT_EN adds a saturating total-match counter on port match_cnt.
module seq_match_logger
    import seq_pkg::*;
#(
    parameter int unsigned POS_W = POS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
`ifdef SEQ_LOG_CNT_EN
    , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seq_det,
    input  logic                     clr_ovf,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [POS_W-1:0]         m_pos,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     ovf
`ifdef SEQ_LOG_CNT_EN
    , output logic [CNT_W-1:0]       match_cnt
`endif
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;

    assign pop  = m_valid && m_ready;
    assign drop = seq_det && full && !pop;

    seq_log_fifo #(
        .W     (POS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (seq_det),
        .pop_i   (m_ready),
        .din_i   (pos_q),
        .dout_o  (m_pos),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign m_valid = !empty;
    assign ovf     = ovf_q;

    // A drop in the same cycle as clr_ovf must leave the flag set.
    always_comb begin
        pos_d = pos_q + POS_W'(1);
        ovf_d = ovf_q;
        if (clr_ovf)
            ovf_d = 1'b0;
        if (drop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef SEQ_LOG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (seq_det && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_match_logger.sv
// Scoreboard bench for seq_match_logger: expected positions are queued at stimulus time
// and popped by a monitor on every accepted handshake; status outputs are checked directly.
module tb_seq_match_logger;

    logic        clk = 1'b0;
    logic        rst, clr_ovf, m_ready, m_valid, ovf;
    logic        force_det, det_en, ip;
    logic        seq_det;
    logic [15:0] m_pos;
    logic [2:0]  level;
    logic [2:0]  hist;

    logic        rst2, det2, w_valid, w_ovf;
    logic [3:0]  w_pos;
    logic [2:0]  w_level;
`ifdef SEQ_LOG_CNT_EN
    logic [7:0]  match_cnt;
    logic [1:0]  w_cnt;
`endif

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    // Behavioural Mealy 1001 detector feeding the DUT, plus a direct force path.
    always @(posedge clk) begin
        if (rst) hist <= 3'b000;
        else if (det_en) hist <= {hist[1:0], ip};
    end
    assign seq_det = force_det | (det_en & ip & (hist == 3'b100));

    seq_match_logger #(
        .POS_W (16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seq_det   (seq_det),
        .clr_ovf   (clr_ovf),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_pos     (m_pos),
        .level     (level),
        .ovf       (ovf)
`ifdef SEQ_LOG_CNT_EN
        , .match_cnt (match_cnt)
`endif
    );

    seq_match_logger #(
        .POS_W (4),
        .DEPTH (4)
`ifdef SEQ_LOG_CNT_EN
        , .CNT_W (2)
`endif
    ) dut_w (
        .clk       (clk),
        .rst       (rst2),
        .seq_det   (det2),
        .clr_ovf   (1'b0),
        .m_valid   (w_valid),
        .m_ready   (1'b0),
        .m_pos     (w_pos),
        .level     (w_level),
        .ovf       (w_ovf)
`ifdef SEQ_LOG_CNT_EN
        , .match_cnt (w_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake must present the oldest expected position.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_pop: got m_pos %0d, expected no entry", m_pos);
            end else begin
                if (m_pos === sb[0]) n_pass++;
                else $display("FAIL sb_pos: got %0d, expected %0d", m_pos, sb[0]);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [10:0] bits;
        rst = 1'b1; rst2 = 1'b1; det2 = 1'b0;
        clr_ovf = 1'b0; m_ready = 1'b0; force_det = 1'b0; det_en = 1'b0; ip = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_pos",   {16'd0, m_pos}, 0);
        chk("rst_level", {29'd0, level}, 0);
        chk("rst_ovf",   {31'd0, ovf}, 0);
`ifdef SEQ_LOG_CNT_EN
        chk("rst_cnt",   {24'd0, match_cnt}, 0);
`endif

        // 1: detector stream, matches complete at bits 3 and 10
        rst = 1'b0; det_en = 1'b1;
        bits = 11'b100_1000_1001;      // bit i is ip at pos i
        sb.push_back(16'd3); sb.push_back(16'd10);
        for (int i = 0; i < 11; i++) begin
            ip = bits[i];
            tick();
        end
        det_en = 1'b0; ip = 1'b0;
        chk("t1_level", {29'd0, level}, 2);
        chk("t1_valid", {31'd0, m_valid}, 1);
        chk("t1_head",  {16'd0, m_pos}, 3);
        m_ready = 1'b1;
        tick(); tick();
        m_ready = 1'b0;
        chk("t1_drained", {31'd0, m_valid}, 0);

        // 2: six back-to-back detections from pos 0 into a 4-deep FIFO
        rst = 1'b1; tick(); rst = 1'b0;
        force_det = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(16'(i));
        tick();
        chk("t2_latency", {31'd0, m_valid}, 1);
        tick(); tick(); tick();
        chk("t2_full_level", {29'd0, level}, 4);
        chk("t2_ovf_pre",    {31'd0, ovf}, 0);
        tick();
        chk("t2_ovf_rise",   {31'd0, ovf}, 1);
        tick();
        force_det = 1'b0;
        chk("t2_level", {29'd0, level}, 4);
        chk("t2_head",  {16'd0, m_pos}, 0);
`ifdef SEQ_LOG_CNT_EN
        chk("t2_cnt", {24'd0, match_cnt}, 6);
`endif

        // 3: push at pos 6 with simultaneous pop while full
        force_det = 1'b1; m_ready = 1'b1;
        sb.push_back(16'd6);
        tick();
        force_det = 1'b0; m_ready = 1'b0;
        chk("t3_level", {29'd0, level}, 4);
        chk("t3_ovf",   {31'd0, ovf}, 1);
        chk("t3_head",  {16'd0, m_pos}, 1);

        // 4: clear, then drop+clear together, then clear alone
        clr_ovf = 1'b1; tick();
        chk("t4_clr", {31'd0, ovf}, 0);
        force_det = 1'b1; tick();
        force_det = 1'b0;
        chk("t4_set_wins", {31'd0, ovf}, 1);
        chk("t4_level",    {29'd0, level}, 4);
        tick();
        clr_ovf = 1'b0;
        chk("t4_clr2", {31'd0, ovf}, 0);
`ifdef SEQ_LOG_CNT_EN
        chk("t4_cnt", {24'd0, match_cnt}, 8);
`endif
        m_ready = 1'b1;
        tick(); tick(); tick(); tick();
        m_ready = 1'b0;
        chk("t4_empty", {31'd0, m_valid}, 0);
        chk("t4_hold",  {16'd0, m_pos}, 6);

        // 5: reset with three queued entries and a live detection
        rst = 1'b1; tick(); rst = 1'b0;
        force_det = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(16'(i));
        tick(); tick(); tick();
        chk("t5_level_pre", {29'd0, level}, 3);
        rst = 1'b1; tick();
        sb.delete();
        rst = 1'b0; force_det = 1'b0;
        chk("t5_level", {29'd0, level}, 0);
        chk("t5_valid", {31'd0, m_valid}, 0);
        chk("t5_pos",   {16'd0, m_pos}, 0);
        chk("t5_ovf",   {31'd0, ovf}, 0);
        for (int i = 0; i < 5; i++) tick();
        force_det = 1'b1;
        sb.push_back(16'd5);
        tick();
        force_det = 1'b0;
        chk("t5_head", {16'd0, m_pos}, 5);
`ifdef SEQ_LOG_CNT_EN
        chk("t5_cnt", {24'd0, match_cnt}, 1);
`endif
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t5_drained", {31'd0, m_valid}, 0);

        // 6: 4-bit position counter wraps; detection at pos 17 logs 1
        rst2 = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        det2 = 1'b1; tick(); det2 = 1'b0;
        chk("t6_wrap",  {28'd0, w_pos}, 1);
        chk("t6_level", {29'd0, w_level}, 1);
        det2 = 1'b1;
        tick(); tick(); tick(); tick();
        det2 = 1'b0;
        chk("t6_full", {29'd0, w_level}, 4);
        chk("t6_ovf",  {31'd0, w_ovf}, 1);
        chk("t6_head", {28'd0, w_pos}, 1);
`ifdef SEQ_LOG_CNT_EN
        chk("t6_sat", {30'd0, w_cnt}, 3);
`endif

        tick();
        chk("sb_leftover", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
